mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Sequencer for the execute-stage multiply/divide unit of the dual-issue MIPS core. It accepts one MULT/MULTU/DIV/DIVU from the master E slot and runs it to completion: a 2-cycle multiply or a 32-iteration radix-2 divide. While the operation is in flight it raises `alu_stall`, which drives the hazard unit's `E_alu_stall` and freezes the pipeline. It presents HI/LO once the result is ready and supports cancellation on a memory-stage exception or an E flush.

## Interface
Parameters:
- `WIDTH`, 32: operand width. The divide iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  clock. One clock domain, rising edge.
- `rst`  in  1  reset. Synchronous and active-high.
- `op_valid`  in  1  the master E instruction is a mul/div op.
- `op`  in  2  operation code (`mdu_pkg::mdu_op_t`).
- `src_a`  in  WIDTH  rs value (multiplicand or dividend).
- `src_b`  in  WIDTH  rt value (multiplier or divisor).
- `E_ena`  in  1  E stage advances this cycle.
- `cancel`  in  1  `M_except | E_flush`; aborts the current operation.
- `alu_stall`  out  1  operation not yet complete; feeds `E_alu_stall`.
- `result_valid`  out  1  `hi`/`lo` are valid for the instruction in E.
- `hi`  out  WIDTH  remainder or product high word.
- `lo`  out  WIDTH  quotient or product low word.

## Operation
- FSM states: IDLE, MUL, DIV, DONE. Reset puts the FSM in IDLE with `alu_stall`=0, `result_valid`=0, `hi`=`lo`=0, and the iteration counter at 0.
- IDLE with `op_valid` & ~`cancel`:
  - Latch `op`, `src_a` and `src_b`.
  - `alu_stall`=1 in the same cycle (combinational).
  - A mult op goes to MUL. A div op goes to DIV, except when `src_b`=0, which goes directly to DONE.
- MUL: registers the full 2·WIDTH product (signed for MULT, unsigned for MULTU), then goes to DONE. `alu_stall`=1.
- DIV (`div_iter` sub-module):
  - Restoring divide on operand magnitudes, one quotient bit per cycle, with the counter running 0..WIDTH-1.
  - At counter = WIDTH-1, apply sign fix-up and go to DONE.
  - Fix-up for DIV: quotient negated if sign(a)^sign(b); remainder takes the sign of a. DIVU: no fix-up.
  - `alu_stall`=1 throughout DIV.
- Divide by zero: `hi`=`src_a`, `lo`={WIDTH{1}}, for both signed and unsigned.
- DONE: `alu_stall`=0 and `result_valid`=1.
  - `E_ena`=1 → IDLE. `result_valid` drops the next cycle.
  - `E_ena`=0 (another stall source is active) → stay in DONE holding `hi`/`lo`. The same E instruction must not restart.
- `cancel` in any state: go to IDLE next cycle, and force `alu_stall`=0 and `result_valid`=0 combinationally that same cycle. Operand and counter state is discarded.
- `op_valid` is ignored outside IDLE. The E-stage instruction is frozen by `alu_stall`, so inputs are stable.
- `op_valid`=0 in IDLE: `alu_stall`=0, no state change.

## Timing
Cycle 0 is the first cycle the op is in E with `op_valid`=1.
- MULT/MULTU: `alu_stall`=1 in cycles 0–1. In cycle 2, `alu_stall`=0 and `result_valid`=1. Total 2 stall cycles.
- DIV/DIVU: `alu_stall`=1 in cycles 0..WIDTH (33 stall cycles at WIDTH=32). DONE in cycle WIDTH+1.
- Divide by zero: 1 stall cycle. DONE in cycle 1.
- Back-to-back mdu ops: the second op is accepted in the first IDLE cycle after DONE & `E_ena`. There is no bubble beyond the DONE cycle.
- `rst` mid-operation behaves exactly like `cancel`, except that `hi`/`lo` also clear.
- `cancel` and the DONE transition in the same cycle: `cancel` wins, and `result_valid`=0.

## Structure
- `mdu_pkg` holds:
  - `typedef enum logic [1:0] mdu_op_t` with MDU_MULT=2'b00, MDU_MULTU=2'b01, MDU_DIV=2'b10, MDU_DIVU=2'b11.
  - The FSM state enum.
  - A helper `is_signed(op)` = ~op[0].
- Sub-module `div_iter` contains the remainder/quotient shift registers and the counter, with `start`, `abort`, and `done` pulses. `mdu_ctrl` owns the FSM, the multiplier, and the sign fix-up.

## Test plan
- MULT a=0xFFFFFFFF, b=2, `E_ena`=1 → `alu_stall` high exactly cycles 0–1. Cycle 2: `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE, `result_valid`=1.
- DIV a=0xFFFFFFF9 (−7), b=2 → 33 stall cycles. Then `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU with the same operands → `lo`=0x7FFFFFFC, `hi`=1.
- DIVU b=0, a=0x1234 → 1 stall cycle. Then `hi`=0x1234, `lo`=0xFFFFFFFF.
- MULTU 3×5 finishing while `E_ena`=0 for 4 cycles → remains in DONE, no restart, `hi`/`lo`=0/15 held, returns to IDLE on the cycle `E_ena`=1.
- `cancel` pulsed in cycle 10 of a DIV → `alu_stall`=0 in cycle 10, FSM in IDLE in cycle 11, `result_valid` never asserted. A new MULT accepted in cycle 11 completes normally.
- `rst` asserted during DIV → all outputs zero next cycle, FSM IDLE.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide sequencer: op codes, FSM states and small helpers.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_t;

  function automatic logic is_signed(mdu_op_t op);
    return ~op[0];
  endfunction

  function automatic logic is_div(mdu_op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage <-> mdu bundle. The E stage presents an op with op_valid; the unit holds the
// pipeline with alu_stall until hi/lo are ready and result_valid is high, then E_ena retires it.
interface mdu_ctrl_if #(parameter int WIDTH = 32);
  import mdu_pkg::*;

  logic             op_valid;
  mdu_op_t          op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             E_ena;
  logic             cancel;
  logic             alu_stall;
  logic             result_valid;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  mdu_state_t       dbg_state;

  modport master (
    output op_valid, op, src_a, src_b, E_ena, cancel,
    input  alu_stall, result_valid, hi, lo, dbg_state
  );

  modport slave (
    input  op_valid, op, src_a, src_b, E_ena, cancel,
    output alu_stall, result_valid, hi, lo, dbg_state
  );
endinterface

// File: rtl/mdu_ctrl_div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes; one quotient bit per cycle, WIDTH cycles.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);
  localparam int CW = $clog2(WIDTH);

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  // Quotient register doubles as the dividend shifter: its MSB feeds the remainder.
  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]};
    diff  = trial - {1'b0, dvs_q};
    rem_d = trial[WIDTH-1:0];
    quo_d = {quo_q[WIDTH-2:0], 1'b0};
    if (trial >= {1'b0, dvs_q}) begin
      rem_d = diff[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  assign done_o = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign quot_o = quo_d;
  assign rem_o  = rem_d;

  always_ff @(posedge clk_i) begin
    if (rst_i || abort_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvs_q  <= divisor_i;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      if (done_o) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end
endmodule

// File: rtl/mdu_ctrl.sv
// Execute-stage mul/div sequencer: owns the FSM, the 2-cycle multiplier and divide sign fix-up.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  mdu_ctrl_if.slave bus
);
  mdu_state_t       state_q;
  mdu_op_t          op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             accept, sgn_now, sgn_q;
  logic             div_start, div_done;
  logic [WIDTH-1:0] mag_a, mag_b, quot, rem, q_fix, r_fix;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;

  assign accept    = (state_q == ST_IDLE) && bus.op_valid && !bus.cancel;
  assign sgn_now   = is_signed(bus.op);
  assign sgn_q     = is_signed(op_q);
  assign div_start = accept && is_div(bus.op) && (bus.src_b != '0);

  assign mag_a = (sgn_now && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
  assign mag_b = (sgn_now && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (div_start),
    .abort_i    (bus.cancel),
    .dividend_i (mag_a),
    .divisor_i  (mag_b),
    .done_o     (div_done),
    .quot_o     (quot),
    .rem_o      (rem)
  );

  // Sign-extending to 2*WIDTH makes one unsigned multiply serve both MULT and MULTU.
  assign a_ext = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
  assign b_ext = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
  assign prod  = a_ext * b_ext;

  assign q_fix = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quot : quot;
  assign r_fix = (sgn_q && a_q[WIDTH-1]) ? -rem : rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= MDU_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (bus.cancel) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.op_valid) begin
          op_q <= bus.op;
          a_q  <= bus.src_a;
          b_q  <= bus.src_b;
          if (!is_div(bus.op)) begin
            state_q <= ST_MUL;
          end else if (bus.src_b == '0) begin
            hi_q    <= bus.src_a;
            lo_q    <= '1;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_DIV;
          end
        end
        ST_MUL: begin
          {hi_q, lo_q} <= prod;
          state_q      <= ST_DONE;
        end
        ST_DIV: if (div_done) begin
          hi_q    <= r_fix;
          lo_q    <= q_fix;
          state_q <= ST_DONE;
        end
        ST_DONE: if (bus.E_ena) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.alu_stall    = !rst && (accept || (!bus.cancel &&
                            (state_q == ST_MUL || state_q == ST_DIV)));
  assign bus.result_valid = !rst && !bus.cancel && (state_q == ST_DONE);
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;
  assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed and random bench for mdu_ctrl against an arithmetic reference model.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_ctrl_if #(.WIDTH(W)) bus ();
  mdu_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference results from plain 64-bit arithmetic; pushes hi then lo.
  function automatic void model(input mdu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, sp;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MDU_MULT: begin
        sp = sa * sb;
        exp_q.push_back(sp[63:32]);
        exp_q.push_back(sp[31:0]);
      end
      MDU_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        exp_q.push_back(up[63:32]);
        exp_q.push_back(up[31:0]);
      end
      default: begin
        if (b == 0) begin
          exp_q.push_back(a);
          exp_q.push_back('1);
        end else if (op == MDU_DIV) begin
          sp = sa % sb;
          exp_q.push_back(sp[31:0]);
          sp = sa / sb;
          exp_q.push_back(sp[31:0]);
        end else begin
          exp_q.push_back(a % b);
          exp_q.push_back(a / b);
        end
      end
    endcase
  endfunction

  function automatic int exp_stalls(input mdu_op_t op, input logic [W-1:0] b);
    if (!op[1]) return 2;
    if (b == 0) return 1;
    return W + 1;
  endfunction

  task automatic drive_op(input mdu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.op_valid = 1'b1;
    bus.op       = op;
    bus.src_a    = a;
    bus.src_b    = b;
  endtask

  // Called just after a rising edge; leaves the bench just after the edge that retires the op.
  task automatic run_op(input string tag, input mdu_op_t op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    int cyc = 0;
    int stalls = 0;
    bit got = 0;
    logic [W-1:0] eh, el;
    drive_op(op, a, b);
    model(op, a, b);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.result_valid) begin
        got = 1;
        break;
      end
      if (bus.alu_stall) stalls++;
      cyc++;
    end
    eh = exp_q.pop_front();
    el = exp_q.pop_front();
    chk({tag, "_done"}, 64'(got), 64'd1);
    chk({tag, "_stalls"}, 64'(stalls), 64'(exp_stalls(op, b)));
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_stalls(op, b)));
    chk({tag, "_hi"}, 64'(bus.hi), 64'(eh));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(el));
    chk({tag, "_stall_in_done"}, 64'(bus.alu_stall), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen_rv;
    mdu_op_t rop;
    logic [W-1:0] ra, rb;
    logic [W-1:0] eh, el;

    rst = 1'b1;
    bus.op_valid = 1'b0;
    bus.op = MDU_MULT;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.E_ena = 1'b1;
    bus.cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_stall", 64'(bus.alu_stall), 64'd0);
    chk("reset_rv", 64'(bus.result_valid), 64'd0);
    chk("reset_hi", 64'(bus.hi), 64'd0);
    chk("reset_lo", 64'(bus.lo), 64'd0);
    chk("reset_state", 64'(bus.dbg_state), 64'(ST_IDLE));
    @(posedge clk);
    #1;

    // Directed ops, issued back to back.
    run_op("mult_m1x2", MDU_MULT, 32'hFFFF_FFFF, 32'd2);
    run_op("div_m7d2", MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_m7d2", MDU_DIVU, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_by0", MDU_DIVU, 32'h0000_1234, 32'd0);
    run_op("div_by0", MDU_DIV, 32'h8000_0001, 32'd0);
    bus.op_valid = 1'b0;
    @(negedge clk);
    chk("idle_after_retire_rv", 64'(bus.result_valid), 64'd0);
    chk("idle_after_retire_state", 64'(bus.dbg_state), 64'(ST_IDLE));
    @(posedge clk);
    #1;

    // Result held while another stall source keeps E frozen.
    bus.E_ena = 1'b0;
    drive_op(MDU_MULTU, 32'd3, 32'd5);
    model(MDU_MULTU, 32'd3, 32'd5);
    eh = exp_q.pop_front();
    el = exp_q.pop_front();
    seen_rv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.result_valid) begin
        seen_rv = 1;
        break;
      end
    end
    chk("hold_done", 64'(seen_rv), 64'd1);
    for (int k = 0; k < 4; k++) begin
      chk("hold_state", 64'(bus.dbg_state), 64'(ST_DONE));
      chk("hold_rv", 64'(bus.result_valid), 64'd1);
      chk("hold_stall", 64'(bus.alu_stall), 64'd0);
      chk("hold_hi", 64'(bus.hi), 64'(eh));
      chk("hold_lo", 64'(bus.lo), 64'(el));
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.E_ena = 1'b1;
    @(negedge clk);
    chk("hold_release_rv", 64'(bus.result_valid), 64'd1);
    @(posedge clk);
    #1 bus.op_valid = 1'b0;
    @(negedge clk);
    chk("hold_idle_state", 64'(bus.dbg_state), 64'(ST_IDLE));
    chk("hold_idle_lo", 64'(bus.lo), 64'(el));
    @(posedge clk);
    #1;

    // Cancel in cycle 10 of a divide, then a fresh MULT in cycle 11.
    drive_op(MDU_DIV, 32'd100, 32'd7);
    seen_rv = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.result_valid) seen_rv = 1;
      if (c == 9) chk("cancel_pre_stall", 64'(bus.alu_stall), 64'd1);
      @(posedge clk);
      #1;
    end
    bus.cancel = 1'b1;
    @(negedge clk);
    chk("cancel_stall", 64'(bus.alu_stall), 64'd0);
    chk("cancel_rv", 64'(bus.result_valid), 64'd0);
    @(posedge clk);
    #1 bus.cancel = 1'b0;
    chk("cancel_state_idle", 64'(bus.dbg_state), 64'(ST_IDLE));
    chk("cancel_no_rv", 64'(seen_rv), 64'd0);
    run_op("mult_after_cancel", MDU_MULT, 32'h0001_2345, 32'hFFFF_FF00);

    // Random back-to-back ops, some divide-by-zero and small divisors.
    for (int n = 0; n < 24; n++) begin
      rop = mdu_op_t'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 9));
        2:       rb = -W'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      run_op("rand", rop, ra, rb);
    end
    run_op("multu_3x5", MDU_MULTU, 32'd3, 32'd5);

    // Synchronous reset mid-divide.
    drive_op(MDU_DIV, 32'hDEAD_BEEF, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.op_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", 64'(bus.alu_stall), 64'd0);
    chk("rst_rv", 64'(bus.result_valid), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_state", 64'(bus.dbg_state), 64'(ST_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
